// File: rtl/io_pkg.sv
// Shared constants and helpers for the pad input filter slice.
package io_pkg;

  localparam int unsigned default_stable_cycles = 16;

  // Ceiling log2; sizes a counter that must hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_input_filter_if.sv
// Pad-side and filtered-side signals of io_input_filter.
interface io_input_filter_if #(
  parameter int unsigned width = 8
);
  logic             Enable;
  logic [width-1:0] In;
  logic [width-1:0] Out;
  logic [width-1:0] Rise;
  logic [width-1:0] Fall;
  logic             Changed;

  modport master (output Enable, In, input Out, Rise, Fall, Changed);
  modport slave  (input Enable, In, output Out, Rise, Fall, Changed);
endinterface

// File: rtl/io_bit_filter.sv
// One pad bit: two-flop synchronizer, stability counter, edge pulses.
module io_bit_filter
  import io_pkg::*;
#(
  parameter int unsigned stable_cycles = default_stable_cycles
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int unsigned cw = clog2(stable_cycles + 1);

  (* iob = "true" *) logic s1;
  logic          s2;
  logic [cw-1:0] cnt;
  logic          last;

  // accept is the next-cycle pulse, exported so the top can register Changed alongside rise/fall.
  always_comb begin
    last   = (32'(cnt) + 32'd1 == stable_cycles);
    accept = Enable && (s2 != level) && last;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= pad;
      s2   <= s1;
      rise <= accept && s2;
      fall <= accept && !s2;
      if (Enable) begin
        if (s2 == level) begin
          cnt <= '0;
        end else if (last) begin
          cnt   <= '0;
          level <= s2;
        end else begin
          cnt <= cnt + cw'(1);
        end
      end
    end
  end

endmodule

// File: rtl/io_input_filter.sv
// Debounced pad inputs: per-bit filters plus a registered any-edge flag.
module io_input_filter
  import io_pkg::*;
#(
  parameter int unsigned width         = 8,
  parameter int unsigned stable_cycles = default_stable_cycles
) (
  input logic              Clock,
  input logic              Reset,
  io_input_filter_if.slave bus
);

  logic [width-1:0] accept;
  logic [width-1:0] out_v;
  logic [width-1:0] rise_v;
  logic [width-1:0] fall_v;

  for (genvar i = 0; i < width; i++) begin : g_bit
    io_bit_filter #(.stable_cycles(stable_cycles)) u_bit (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (bus.Enable),
      .pad    (bus.In[i]),
      .level  (out_v[i]),
      .rise   (rise_v[i]),
      .fall   (fall_v[i]),
      .accept (accept[i])
    );
  end

  assign bus.Out  = out_v;
  assign bus.Rise = rise_v;
  assign bus.Fall = fall_v;

  always_ff @(posedge Clock) begin
    if (Reset) bus.Changed <= 1'b0;
    else       bus.Changed <= |accept;
  end

endmodule

// File: tb/tb_io_input_filter.sv
// Directed bench for io_input_filter with stable_cycles 4 and 1 instances.
module tb_io_input_filter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic [7:0] In = 8'h00;

  always #5 Clock = ~Clock;

  io_input_filter_if #(.width(8)) bus4 ();
  io_input_filter_if #(.width(8)) bus1 ();

  assign bus4.Enable = Enable;
  assign bus4.In     = In;
  assign bus1.Enable = Enable;
  assign bus1.In     = In;

  io_input_filter #(.width(8), .stable_cycles(4)) dut4 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus4)
  );

  io_input_filter #(.width(8), .stable_cycles(1)) dut1 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic checking = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pad value is seen two edges later; a bit flips once it has
  // disagreed with the accepted level for N consecutive enabled edges.
  logic [7:0] pipe1 = '0, pipe2 = '0;
  logic [7:0] m_out [2] = '{8'h00, 8'h00};
  logic [7:0] m_rise[2] = '{8'h00, 8'h00};
  logic [7:0] m_fall[2] = '{8'h00, 8'h00};
  logic       m_chg [2] = '{1'b0, 1'b0};
  int         run   [2][8];
  int         ncyc  [2] = '{4, 1};

  always @(posedge Clock) begin
    for (int d = 0; d < 2; d++) begin
      m_rise[d] = '0;
      m_fall[d] = '0;
      if (Reset) begin
        m_out[d] = '0;
        for (int b = 0; b < 8; b++) run[d][b] = 0;
      end else if (Enable) begin
        for (int b = 0; b < 8; b++) begin
          if (pipe2[b] == m_out[d][b]) begin
            run[d][b] = 0;
          end else begin
            run[d][b] = run[d][b] + 1;
            if (run[d][b] >= ncyc[d]) begin
              m_out[d][b] = pipe2[b];
              if (pipe2[b]) m_rise[d][b] = 1'b1;
              else          m_fall[d][b] = 1'b1;
              run[d][b] = 0;
            end
          end
        end
      end
      m_chg[d] = |(m_rise[d] | m_fall[d]);
    end
    pipe2 = Reset ? 8'h00 : pipe1;
    pipe1 = Reset ? 8'h00 : In;
  end

  always @(negedge Clock) begin
    if (checking) begin
      cmp("out4",  bus4.Out,     m_out[0]);
      cmp("rise4", bus4.Rise,    m_rise[0]);
      cmp("fall4", bus4.Fall,    m_fall[0]);
      cmp("chg4",  bus4.Changed, m_chg[0]);
      cmp("out1",  bus1.Out,     m_out[1]);
      cmp("rise1", bus1.Rise,    m_rise[1]);
      cmp("fall1", bus1.Fall,    m_fall[1]);
      cmp("chg1",  bus1.Changed, m_chg[1]);
      cmp("overlap4", bus4.Rise & bus4.Fall, 0);
      cmp("overlap1", bus1.Rise & bus1.Fall, 0);
    end
  end

  initial begin
    logic [7:0] seen;
    logic       prev;

    Reset = 1'b1; Enable = 1'b0; In = 8'h00;
    repeat (2) @(negedge Clock);
    checking = 1'b1;
    cmp("rst_out",  bus4.Out, 8'h00);
    cmp("rst_rise", bus4.Rise, 8'h00);
    cmp("rst_chg",  bus4.Changed, 0);

    // Single bit rise, 5 edges after capture
    Reset = 1'b0; Enable = 1'b1; In = 8'h01;
    repeat (5) @(negedge Clock);
    cmp("r26_pre_out", bus4.Out, 8'h00);
    @(negedge Clock);
    cmp("r26_out",  bus4.Out, 8'h01);
    cmp("r26_rise", bus4.Rise, 8'h01);
    cmp("r26_chg",  bus4.Changed, 1);
    @(negedge Clock);
    cmp("r26_rise_end", bus4.Rise, 8'h00);
    cmp("r26_chg_end",  bus4.Changed, 0);

    // Short pulse is rejected
    Reset = 1'b1; In = 8'h00;
    repeat (2) @(negedge Clock);
    Reset = 1'b0; In = 8'h01;
    seen = '0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) In = 8'h00;
      @(negedge Clock);
      seen = seen | bus4.Rise | bus4.Fall;
    end
    cmp("r27_nopulse", seen, 8'h00);
    cmp("r27_out", bus4.Out, 8'h00);

    // Enable gap stretches acceptance by two cycles
    In = 8'h81;
    repeat (4) @(negedge Clock);
    Enable = 1'b0;
    repeat (2) @(negedge Clock);
    Enable = 1'b1;
    @(negedge Clock);
    cmp("r28_pre_out",  bus4.Out, 8'h00);
    cmp("r28_pre_rise", bus4.Rise, 8'h00);
    @(negedge Clock);
    cmp("r28_out",  bus4.Out, 8'h81);
    cmp("r28_rise", bus4.Rise, 8'h81);
    cmp("r28_chg",  bus4.Changed, 1);
    @(negedge Clock);
    cmp("r28_rise_end", bus4.Rise, 8'h00);

    // Upper nibble falls together
    In = 8'hFF;
    repeat (8) @(negedge Clock);
    cmp("r29_allhigh", bus4.Out, 8'hFF);
    In = 8'h0F;
    repeat (5) @(negedge Clock);
    cmp("r29_pre_fall", bus4.Fall, 8'h00);
    @(negedge Clock);
    cmp("r29_fall", bus4.Fall, 8'hF0);
    cmp("r29_rise", bus4.Rise, 8'h00);
    cmp("r29_out",  bus4.Out, 8'h0F);
    cmp("r29_chg",  bus4.Changed, 1);
    @(negedge Clock);
    cmp("r29_fall_end", bus4.Fall, 8'h00);

    // Reset mid-count discards the count
    Reset = 1'b1; In = 8'h00;
    repeat (2) @(negedge Clock);
    Reset = 1'b0; In = 8'h01;
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      cmp("r30_rst_out",  bus4.Out, 8'h00);
      cmp("r30_rst_rise", bus4.Rise, 8'h00);
      cmp("r30_rst_chg",  bus4.Changed, 0);
    end
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    cmp("r30_pre_out", bus4.Out, 8'h00);
    @(negedge Clock);
    cmp("r30_out",  bus4.Out, 8'h01);
    cmp("r30_rise", bus4.Rise, 8'h01);
    cmp("r30_chg",  bus4.Changed, 1);

    // stable_cycles=1 follows a toggling pad with 2-edge latency
    Reset = 1'b1; In = 8'h00;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      In = (i % 2 == 0) ? 8'h01 : 8'h00;
      @(negedge Clock);
      if (i > 0) begin
        cmp("r31_out",  bus1.Out,  {7'b0, prev});
        cmp("r31_rise", bus1.Rise, {7'b0, prev});
        cmp("r31_fall", bus1.Fall, {7'b0, ~prev});
      end
      @(negedge Clock);
      cmp("r31_quiet", bus1.Rise | bus1.Fall, 8'h00);
      prev = In[0];
    end
    repeat (3) @(negedge Clock);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
